fp_accum: RTL and testbench

- Streaming fixed-point accumulator that sits directly downstream of fp_mult in the LBM datapath.
- Consumes one signed Q8.24 product per handshake and sums a packet of terms, for example the 9 D2Q9 f_i*c_i products for a density or momentum moment.
- Emits one saturated Q8.24 sum per packet.
- Valid/ready on both sides so it can be chained behind a registered fp_mult stage.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_sat.sv | 28 ++
 rtl/fp_accum.sv | 104 ++++++++++
 tb/tb_fp_accum.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared Q8.24 fixed-point definitions for the LBM datapath stages.
package fp_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_FRACTIONAL_BITS = 24;
    localparam int DEFAULT_INTEGER_BITS    = DEFAULT_DATA_WIDTH - DEFAULT_FRACTIONAL_BITS;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] Q_ONE = 32'h01_000000;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] Q_MIN = 32'h8000_0000;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] q_word_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } accum_state_t;

endpackage

// File: rtl/fp_sat.sv
// Combinational clip of a wide signed value into a narrower signed word, with a clip flag.
module fp_sat #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0]  value,
    output logic        [OUT_WIDTH-1:0] result,
    output logic                        clipped
);

    logic [IN_WIDTH-OUT_WIDTH:0] top_bits;

    // The value fits only when every bit from the output sign bit upward agrees.
    always_comb begin
        top_bits = value[IN_WIDTH-1:OUT_WIDTH-1];
        result   = value[OUT_WIDTH-1:0];
        clipped  = 1'b0;
        if (!((&top_bits) || !(|top_bits))) begin
            clipped = 1'b1;
            if (value[IN_WIDTH-1]) begin
                result = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                result = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/fp_accum.sv
// Streaming Q8.24 packet accumulator: sums up to MAX_TERMS terms and emits one saturated sum.
module fp_accum
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int FRACTIONAL_BITS = DEFAULT_FRACTIONAL_BITS,
    parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
    parameter int GUARD_BITS      = 4,
    parameter int MAX_TERMS       = 9
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         Din,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic        [DATA_WIDTH-1:0]         Dout,
    output logic                                 sat,
    output logic [$clog2(MAX_TERMS+1)-1:0]       term_count
);

    localparam int ACC_WIDTH   = INTEGER_BITS + FRACTIONAL_BITS + GUARD_BITS;
    localparam int COUNT_WIDTH = $clog2(MAX_TERMS + 1);

    accum_state_t                 state;
    accum_state_t                 state_next;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic [COUNT_WIDTH-1:0]       cnt;
    logic [COUNT_WIDTH-1:0]       cnt_next;
    logic                         accept;
    logic                         close;
    logic                         release_out;
    logic [DATA_WIDTH-1:0]        clip_value;
    logic                         clip_flag;

    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign acc_next    = acc + ACC_WIDTH'(Din);
    assign cnt_next    = cnt + COUNT_WIDTH'(1);
    // in_last and the term limit on the same term still make only one close.
    assign close       = accept & (in_last | (cnt_next == COUNT_WIDTH'(MAX_TERMS)));
    assign term_count  = cnt;

    fp_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_sat (
        .value   (acc_next),
        .result  (clip_value),
        .clipped (clip_flag)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (close)       state_next = DONE;
            DONE:  if (release_out) state_next = ACCUM;
            default:                state_next = ACCUM;
        endcase
    end

    // Handshake outputs come from state alone so nothing loops through the pipeline.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Intermediate sums run unclipped in the guard bits; only the closing value is saturated.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc  <= '0;
            cnt  <= '0;
            Dout <= '0;
            sat  <= 1'b0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (close) begin
                Dout <= clip_value;
                sat  <= clip_flag;
            end
        end else if (release_out) begin
            acc <= '0;
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Bench for fp_accum: directed packets plus random packets checked against a plain-arithmetic sum model.
module tb_fp_accum;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Din;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Dout;
    logic        sat;
    logic [3:0]  term_count;

    int check_count = 0;
    int pass_count  = 0;

    longint      model_sum;
    int          model_count;
    bit          model_closed;
    logic [31:0] exp_dout;
    logic        exp_sat;
    int          exp_count;

    fp_accum dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Din        (Din),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Dout       (Dout),
        .sat        (sat),
        .term_count (term_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference: packet sum as a 64-bit integer, clipped to 32-bit signed range on close.
    task automatic modelAccept(input logic [31:0] d, input logic last);
        longint max_q;
        longint min_q;
        max_q = (longint'(1) << 31) - 1;
        min_q = -(longint'(1) << 31);
        model_sum   = model_sum + longint'(signed'(d));
        model_count = model_count + 1;
        if (last || model_count == 9) begin
            model_closed = 1'b1;
            exp_count    = model_count;
            if (model_sum > max_q) begin
                exp_dout = 32'h7FFF_FFFF;
                exp_sat  = 1'b1;
            end else if (model_sum < min_q) begin
                exp_dout = 32'h8000_0000;
                exp_sat  = 1'b1;
            end else begin
                exp_dout = model_sum[31:0];
                exp_sat  = 1'b0;
            end
        end
    endtask

    task automatic modelClear();
        model_sum    = 0;
        model_count  = 0;
        model_closed = 1'b0;
    endtask

    // Offers one term after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [31:0] d, input logic last, input int gap);
        int waited;
        waited   = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b1;
        Din      = d;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            @(posedge Clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        modelAccept(d, last);
        checkOutput("term_count_after_accept", {60'd0, term_count}, 64'(model_count));
        checkOutput("out_valid_after_accept", {63'd0, out_valid}, {63'd0, model_closed});
    endtask

    // Checks the held result, stalls for hold_cycles with junk offered, then releases.
    task automatic collectOutput(input int hold_cycles);
        checkOutput("out_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("dout", {32'd0, Dout}, {32'd0, exp_dout});
        checkOutput("sat", {63'd0, sat}, {63'd0, exp_sat});
        checkOutput("term_count_done", {60'd0, term_count}, 64'(exp_count));
        checkOutput("in_ready_done", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;
            Din      = 32'h0100_0000;
            in_last  = (i == 0);
            @(posedge Clk);
            #1;
            checkOutput("hold_dout", {32'd0, Dout}, {32'd0, exp_dout});
            checkOutput("hold_term_count", {60'd0, term_count}, 64'(exp_count));
            checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("hold_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        modelClear();
        checkOutput("release_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("release_term_count", {60'd0, term_count}, 64'd0);
    endtask

    initial begin
        int          len;
        int          sel;
        logic [31:0] d;

        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        Din       = '0;
        out_ready = 1'b0;
        modelClear();
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_dout", {32'd0, Dout}, 64'd0);
        checkOutput("reset_sat", {63'd0, sat}, 64'd0);
        checkOutput("reset_term_count", {60'd0, term_count}, 64'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);

        applyStimulus(32'h0500_0000, 1'b0, 0);
        applyStimulus(32'h0109_0000, 1'b0, 0);
        applyStimulus(32'hFD60_0000, 1'b1, 0);
        checkOutput("three_term_const", {32'd0, Dout}, 64'h0369_0000);
        collectOutput(0);

        for (int i = 0; i < 9; i++) applyStimulus(32'h0100_0000, 1'b0, 0);
        checkOutput("nine_term_const", {32'd0, Dout}, 64'h0900_0000);
        collectOutput(2);

        for (int i = 0; i < 9; i++) applyStimulus(32'h7F00_0000, 1'b0, 0);
        checkOutput("pos_sat_const", {32'd0, Dout}, 64'h7FFF_FFFF);
        collectOutput(0);

        applyStimulus(32'h8000_0000, 1'b0, 0);
        applyStimulus(32'h8000_0000, 1'b1, 0);
        checkOutput("neg_sat_const", {32'd0, Dout}, 64'h8000_0000);
        collectOutput(0);

        applyStimulus(32'h0020_0000, 1'b1, 0);
        collectOutput(3);
        applyStimulus(32'h0040_0000, 1'b1, 0);
        checkOutput("after_backpressure_const", {32'd0, Dout}, 64'h0040_0000);
        collectOutput(0);

        applyStimulus(32'h0200_0000, 1'b0, 0);
        applyStimulus(32'h0200_0000, 1'b0, 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_term_count", {60'd0, term_count}, 64'd0);
        Reset = 1'b0;
        modelClear();
        applyStimulus(32'h0080_0000, 1'b1, 0);
        checkOutput("midreset_const", {32'd0, Dout}, 64'h0080_0000);
        collectOutput(0);

        applyStimulus(32'h0040_0000, 1'b0, 0);
        applyStimulus(32'h0040_0000, 1'b0, 1);
        applyStimulus(32'h0040_0000, 1'b1, 1);
        checkOutput("bursty_const", {32'd0, Dout}, 64'h00C0_0000);
        collectOutput(0);

        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                sel = int'($urandom_range(0, 3));
                if (sel == 0) begin
                    d = $urandom;
                end else if (sel == 1) begin
                    d = {{6{1'b0}}, 26'($urandom)};
                end else if (sel == 2) begin
                    d = {{6{1'b1}}, 26'($urandom)};
                end else begin
                    d = 32'($urandom_range(0, 1)) == 32'd1 ? 32'h7F00_0000 : 32'h8100_0000;
                end
                applyStimulus(d, (i == len - 1), int'($urandom_range(0, 2)));
                if (model_closed) break;
            end
            collectOutput(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
